// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states and frame geometry.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int unsigned PS2_DATA_BITS  = 8;
    localparam int unsigned PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_scan_fifo.sv
// Scan-code FIFO; simultaneous push and pop both take effect, even when full.
module ps2_scan_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: line sync, frame FSM with timeout, scan-code FIFO
// and level interrupt request using the int_req_o/int_fin_i handshake.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          pop_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          int_req_o,
    input  logic                          int_fin_i,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    input  logic                          err_clr_i
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BW = $clog2(PS2_DATA_BITS + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_prev;
    logic                   fall;

    ps2_state_t             state;
    logic [BW-1:0]          bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic [TW-1:0]          tmo_cnt;

    logic                   frame_ok;
    logic                   good_push;
    logic                   tmo_hit;
    logic                   err_set;
    logic                   ovf_set;
    logic                   fifo_full;
    logic                   fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev && !clk_s;

    // Stop bit high and odd parity over data plus parity bit.
    assign frame_ok  = data_s && (^{shreg, par_bit});
    assign good_push = fall && (state == STOP) && frame_ok;
    assign tmo_hit   = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign err_set   = (fall && (state == STOP) && !frame_ok) || tmo_hit;
    assign ovf_set   = good_push && fifo_full && !pop_i;
    assign valid_o   = !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
            int_req_o   <= 1'b0;
        end else begin
            if (err_clr_i) begin
                frame_err_o <= 1'b0;
                overflow_o  <= 1'b0;
            end
            if (err_set)
                frame_err_o <= 1'b1;
            if (ovf_set)
                overflow_o <= 1'b1;

            if (int_fin_i)
                int_req_o <= 1'b0;
            else if (count_o != '0)
                int_req_o <= 1'b1;

            if (state == IDLE || fall)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit) begin
                state <= IDLE;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(PS2_DATA_BITS - 1))
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s;
                        state   <= STOP;
                    end
                    STOP: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    ps2_scan_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (good_push),
        .wdata (shreg),
        .pop   (pop_i),
        .rdata (data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count_o)
    );

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Scoreboard bench for ps2_rx_ctrl: frames push expected bytes, a monitor checks pops.
module tb_ps2_rx_ctrl;

    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned TIMEOUT_CYC = 5000;
    localparam int unsigned H           = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       pop_i;
    logic [3:0] count_o;
    logic       int_req_o;
    logic       int_fin_i;
    logic       frame_err_o;
    logic       overflow_o;
    logic       err_clr_i;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_cnt = 0;

    ps2_rx_ctrl #(
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .pop_i       (pop_i),
        .count_o     (count_o),
        .int_req_o   (int_req_o),
        .int_fin_i   (int_fin_i),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .err_clr_i   (err_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: each effective pop must present the oldest expected byte.
    always @(negedge clk) begin
        if (rst === 1'b1 && pop_i === 1'b1 && valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_data: got 0x%0h expected no entry", data_o);
            end else begin
                chk("pop_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic expect_byte(input logic [7:0] b);
        if (exp_cnt < FIFO_DEPTH) begin
            exp_q.push_back(b);
            exp_cnt++;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data_i = b;
        cyc(H);
        ps2_clk_i = 1'b0;
        cyc(H);
        ps2_clk_i = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] d, input logic par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_head(d, par);
        ps2_bit(stp);
        cyc(2);
    endtask

    task automatic do_pop();
        pop_i = 1'b1;
        cyc(1);
        pop_i = 1'b0;
        if (exp_cnt > 0) exp_cnt--;
    endtask

    task automatic clear_errs();
        err_clr_i = 1'b1;
        cyc(1);
        err_clr_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] seq_d [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    logic       seq_p [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst        = 1'b0;
        ps2_clk_i  = 1'b1;
        ps2_data_i = 1'b1;
        pop_i      = 1'b0;
        int_fin_i  = 1'b0;
        err_clr_i  = 1'b0;
        cyc(3);
        chk("rst_count", count_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_int", int_req_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_ovf", overflow_o, 0);
        rst = 1'b1;
        cyc(2);

        // Frame 0x1C with exact completion latency.
        send_head(8'h1C, 1'b0);
        expect_byte(8'h1C);
        ps2_data_i = 1'b1;
        cyc(H);
        ps2_clk_i = 1'b0;
        cyc(2);
        chk("t1_valid_T", valid_o, 0);
        cyc(1);
        chk("t1_valid_T1", valid_o, 1);
        chk("t1_count", count_o, 1);
        chk("t1_data", data_o, 8'h1C);
        chk("t1_int_T1", int_req_o, 0);
        cyc(1);
        chk("t1_int_T2", int_req_o, 1);
        cyc(H - 4);
        ps2_clk_i = 1'b1;
        cyc(H);
        int_fin_i = 1'b1;
        cyc(1);
        int_fin_i = 1'b0;
        chk("t1_int_fin", int_req_o, 0);
        cyc(1);
        chk("t1_int_reassert", int_req_o, 1);
        do_pop();
        chk("t1_pop_valid", valid_o, 0);
        chk("t1_pop_count", count_o, 0);
        chk("t1_int_after_pop", int_req_o, 1);
        int_fin_i = 1'b1;
        cyc(1);
        int_fin_i = 1'b0;
        cyc(2);
        chk("t1_int_empty", int_req_o, 0);

        // Bad parity, then bad stop bit.
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("t2_par_err", frame_err_o, 1);
        chk("t2_par_count", count_o, 0);
        clear_errs();
        chk("t2_clr", frame_err_o, 0);
        send_frame(8'hF0, 1'b1, 1'b0);
        chk("t2_stop_err", frame_err_o, 1);
        chk("t2_stop_count", count_o, 0);
        clear_errs();

        // Fill, overflow, then push and pop in the same cycle while full.
        for (int k = 0; k < 9; k++) begin
            expect_byte(seq_d[k]);
            send_frame(seq_d[k], seq_p[k], 1'b1);
        end
        chk("t3_count_full", count_o, 8);
        chk("t3_ovf", overflow_o, 1);
        chk("t3_no_ferr", frame_err_o, 0);
        clear_errs();
        chk("t3_ovf_clr", overflow_o, 0);
        send_head(8'h0A, 1'b1);
        exp_q.push_back(8'h0A);
        ps2_data_i = 1'b1;
        cyc(H);
        ps2_clk_i = 1'b0;
        cyc(2);
        pop_i = 1'b1;
        cyc(1);
        pop_i = 1'b0;
        chk("t3_pushpop_count", count_o, 8);
        chk("t3_pushpop_ovf", overflow_o, 0);
        cyc(H - 3);
        ps2_clk_i = 1'b1;
        cyc(H);
        for (int k = 0; k < 8; k++) do_pop();
        chk("t3_drained", count_o, 0);
        chk("t3_drained_valid", valid_o, 0);
        exp_cnt = 0;

        // Truncated frame times out.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        cyc(TIMEOUT_CYC - 100);
        chk("t4_before_tmo", frame_err_o, 0);
        cyc(200);
        chk("t4_tmo_err", frame_err_o, 1);
        chk("t4_tmo_count", count_o, 0);
        clear_errs();
        expect_byte(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("t4_after_count", count_o, 1);
        chk("t4_after_err", frame_err_o, 0);
        do_pop();

        // Reset in the middle of a frame with entries queued.
        expect_byte(8'h11);
        send_frame(8'h11, 1'b1, 1'b1);
        expect_byte(8'h22);
        send_frame(8'h22, 1'b1, 1'b1);
        expect_byte(8'h33);
        send_frame(8'h33, 1'b1, 1'b1);
        chk("t5_count3", count_o, 3);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        chk("t5_count", count_o, 0);
        chk("t5_valid", valid_o, 0);
        chk("t5_data", data_o, 0);
        chk("t5_int", int_req_o, 0);
        chk("t5_ferr", frame_err_o, 0);
        chk("t5_ovf", overflow_o, 0);
        cyc(2);
        expect_byte(8'h29);
        send_frame(8'h29, 1'b0, 1'b1);
        chk("t5_new_count", count_o, 1);
        chk("t5_new_data", data_o, 8'h29);
        do_pop();

        // Falling edge with data high while idle is ignored.
        ps2_bit(1'b1);
        cyc(4);
        chk("t6_err", frame_err_o, 0);
        chk("t6_count", count_o, 0);
        expect_byte(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("t6_next_count", count_o, 1);
        chk("t6_next_err", frame_err_o, 0);
        do_pop();

        cyc(2);
        chk("end_count", count_o, 0);
        chk("end_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
